mmio_timer_responder: RTL

// - Memory-mapped timer/interrupt peripheral; the responder end of the Frost32Cpu memory bus.
// - Decodes req_mem_access/addr/data_inout_access_type/size and answers with data + wait_for_mem.
// - Sits beside MainMem behind a bus mux; drives the CPU interrupt input, replacing hand-driven stimulus.

---
 rtl/mmio_timer_responder_pkg.sv | 34 +++
 rtl/mmio_timer_responder_if.sv | 25 ++
 rtl/mmio_lane_merge.sv | 43 ++++
 rtl/mmio_timer_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_responder_pkg.sv
// Shared types and widths for the memory-mapped timer responder.
package mmio_timer_responder_pkg;

   localparam int unsigned WIDTH_DATA        = 32;
   localparam int unsigned WIDTH_LATENCY_CNT = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_mmio_t;

   typedef enum logic [1:0] {
      REG_CTRL,
      REG_COUNT,
      REG_COMPARE,
      REG_STATUS
   } reg_offset_t;

   // Same encoding as the CPU's data_inout_access_size.
   typedef enum logic [1:0] {
      SIZE_32,
      SIZE_16,
      SIZE_8,
      SIZE_RSVD
   } access_size_t;

   typedef struct packed {
      logic auto_reload;
      logic irq_en;
      logic enable;
   } ctrl_t;

endpackage

// File: rtl/mmio_timer_responder_if.sv
// CPU memory-bus signals between the CPU (master) and the timer responder (slave).
interface mmio_timer_responder_if;
   import mmio_timer_responder_pkg::*;

   logic                  req_mem_access;
   logic [WIDTH_DATA-1:0] addr;
   logic [WIDTH_DATA-1:0] data_in;
   logic                  data_inout_access_type;
   access_size_t          data_inout_access_size;
   logic [WIDTH_DATA-1:0] data_out;
   logic                  wait_for_mem;
   logic                  selected;
   logic                  interrupt;

   modport master (
      output req_mem_access, addr, data_in, data_inout_access_type, data_inout_access_size,
      input  data_out, wait_for_mem, selected, interrupt
   );

   modport slave (
      input  req_mem_access, addr, data_in, data_inout_access_type, data_inout_access_size,
      output data_out, wait_for_mem, selected, interrupt
   );

endinterface

// File: rtl/mmio_lane_merge.sv
// Little-endian sub-word lane handling: read extraction and write merge.
module mmio_lane_merge
   import mmio_timer_responder_pkg::*;
(
   input  logic [WIDTH_DATA-1:0] i_word,
   input  logic [WIDTH_DATA-1:0] i_wdata,
   input  access_size_t          i_size,
   input  logic [1:0]            i_lane,
   output logic [WIDTH_DATA-1:0] o_rdata,
   output logic [WIDTH_DATA-1:0] o_merged,
   output logic [3:0]            o_be
);

   logic [4:0]            w_shamt;
   logic [WIDTH_DATA-1:0] w_low_mask;
   logic [WIDTH_DATA-1:0] w_bit_mask;

   // Lane select, byte enables, zero-extended read and merged write word.
   always_comb begin
      w_shamt    = 5'd0;
      w_low_mask = '1;
      o_be       = 4'b1111;
      case (i_size)
         SIZE_16: begin
            w_shamt    = {i_lane[1], 4'b0000};
            w_low_mask = 32'h0000_ffff;
            o_be       = 4'b0011 << {i_lane[1], 1'b0};
         end
         SIZE_8: begin
            w_shamt    = {i_lane, 3'b000};
            w_low_mask = 32'h0000_00ff;
            o_be       = 4'b0001 << i_lane;
         end
         default: ;
      endcase
      for (int b = 0; b < 4; b++) begin
         w_bit_mask[8*b +: 8] = {8{o_be[b]}};
      end
      o_rdata  = (i_word >> w_shamt) & w_low_mask;
      o_merged = (i_word & ~w_bit_mask) | ((i_wdata << w_shamt) & w_bit_mask);
   end

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped timer/interrupt peripheral answering on the CPU memory bus.
module mmio_timer_responder
   import mmio_timer_responder_pkg::*;
#(
   parameter logic [WIDTH_DATA-1:0] BASE_ADDR = 32'hffff_0000,
   parameter int unsigned           LATENCY   = 2,
   parameter int unsigned           PRESCALE  = 1
) (
   input logic                    i_clk,
   input logic                    i_rst,
   mmio_timer_responder_if.slave  bus_if
);

   localparam logic [WIDTH_LATENCY_CNT-1:0] LAT_LOAD = WIDTH_LATENCY_CNT'(LATENCY - 1);
   localparam logic [WIDTH_DATA-1:0]        PRE_LAST = WIDTH_DATA'(PRESCALE - 1);

   state_mmio_t                  r_state, w_state_nxt;
   logic [WIDTH_LATENCY_CNT-1:0] r_lat_cnt;
   reg_offset_t                  r_off;
   logic [1:0]                   r_lane;
   logic                         r_type;
   access_size_t                 r_size;
   logic [WIDTH_DATA-1:0]        r_wdata;

   ctrl_t                        r_ctrl, w_ctrl_nxt;
   logic [WIDTH_DATA-1:0]        r_count, w_count_nxt, w_count_inc;
   logic [WIDTH_DATA-1:0]        r_compare, w_compare_nxt;
   logic                         r_pending, w_pending_nxt;
   logic [WIDTH_DATA-1:0]        r_pre, w_pre_nxt;

   logic [WIDTH_DATA-1:0]        r_data_out;
   logic                         r_wait, r_sel, r_irq;

   logic                         w_hit, w_accept, w_commit, w_rd, w_wr;
   logic                         w_tick, w_match, w_wr_count, w_clear;
   logic [WIDTH_DATA-1:0]        w_reg_word, w_rdata, w_merged;
   logic [3:0]                   w_be;

   assign w_hit = bus_if.req_mem_access
               && (bus_if.addr[31:4] == BASE_ADDR[31:4])
               && (bus_if.data_inout_access_size != SIZE_RSVD);

   // Next-state logic; w_commit marks the edge that enters RESP.
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: if (w_hit) w_state_nxt = BUSY;
         BUSY: begin
            if ((r_lat_cnt == '0) && r_wait) begin
               w_state_nxt = RESP;
               w_commit    = 1'b1;
            end
         end
         RESP:    w_state_nxt = w_hit ? BUSY : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   assign w_accept = (w_state_nxt == BUSY) && (r_state != BUSY);
   assign w_rd     = w_commit && !r_type;
   assign w_wr     = w_commit && r_type;

   // Request capture and wait-cycle down-counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lat_cnt <= '0;
         r_off     <= REG_CTRL;
         r_lane    <= 2'b00;
         r_type    <= 1'b0;
         r_size    <= SIZE_32;
         r_wdata   <= '0;
      end else if (w_accept) begin
         r_lat_cnt <= LAT_LOAD;
         r_off     <= reg_offset_t'(bus_if.addr[3:2]);
         r_lane    <= bus_if.addr[1:0];
         r_type    <= bus_if.data_inout_access_type;
         r_size    <= bus_if.data_inout_access_size;
         r_wdata   <= bus_if.data_in;
      end else if ((r_state == BUSY) && (r_lat_cnt != '0)) begin
         r_lat_cnt <= r_lat_cnt - WIDTH_LATENCY_CNT'(1);
      end
   end

   // Register read mux for the latched offset.
   always_comb begin
      w_reg_word = '0;
      case (r_off)
         REG_CTRL:    w_reg_word = WIDTH_DATA'(r_ctrl);
         REG_COUNT:   w_reg_word = r_count;
         REG_COMPARE: w_reg_word = r_compare;
         REG_STATUS:  w_reg_word = WIDTH_DATA'(r_pending);
         default:     w_reg_word = '0;
      endcase
   end

   mmio_lane_merge u_lane_merge (
      .i_word   (w_reg_word),
      .i_wdata  (r_wdata),
      .i_size   (r_size),
      .i_lane   (r_lane),
      .o_rdata  (w_rdata),
      .o_merged (w_merged),
      .o_be     (w_be)
   );

   // Timer and register next values; CPU COUNT write beats the increment, match beats clear.
   always_comb begin
      w_tick      = r_ctrl.enable && (r_pre == PRE_LAST);
      w_pre_nxt   = r_pre;
      if (r_ctrl.enable) w_pre_nxt = w_tick ? '0 : r_pre + WIDTH_DATA'(1);
      w_count_inc = r_count + WIDTH_DATA'(1);
      w_wr_count  = w_wr && (r_off == REG_COUNT);
      w_match     = w_tick && !w_wr_count && (w_count_inc == r_compare);
      w_clear     = w_wr && (r_off == REG_STATUS) && w_be[0] && w_merged[0];

      w_count_nxt = r_count;
      if (w_tick) w_count_nxt = (w_match && r_ctrl.auto_reload) ? '0 : w_count_inc;
      if (w_wr_count) w_count_nxt = w_merged;

      w_compare_nxt = (w_wr && (r_off == REG_COMPARE)) ? w_merged : r_compare;
      w_ctrl_nxt    = (w_wr && (r_off == REG_CTRL)) ? ctrl_t'(w_merged[2:0]) : r_ctrl;
      w_pending_nxt = w_match || (r_pending && !w_clear);
   end

   // Timer and register file state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ctrl    <= '0;
         r_count   <= '0;
         r_compare <= '0;
         r_pending <= 1'b0;
         r_pre     <= '0;
      end else begin
         r_ctrl    <= w_ctrl_nxt;
         r_count   <= w_count_nxt;
         r_compare <= w_compare_nxt;
         r_pending <= w_pending_nxt;
         r_pre     <= w_pre_nxt;
      end
   end

   // Registered bus outputs, derived from next state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data_out <= '0;
         r_wait     <= 1'b0;
         r_sel      <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_rd) r_data_out <= w_rdata;
         r_wait <= (w_state_nxt == BUSY);
         r_sel  <= (w_state_nxt != IDLE);
         r_irq  <= w_pending_nxt && w_ctrl_nxt.irq_en;
      end
   end

   assign bus_if.data_out     = r_data_out;
   assign bus_if.wait_for_mem = r_wait;
   assign bus_if.selected     = r_sel;
   assign bus_if.interrupt    = r_irq;

endmodule
